// File: rtl/cpu_pkg.sv
// Shared encodings for the EX/MEM condition-code and branch logic.
// Branch types, ALU op classes and flag bit positions within {Z,N,C}.
// Pure declarations, no logic.
package cpu_pkg;

  localparam logic [2:0] BR_NONE = 3'd0;
  localparam logic [2:0] BR_JZ   = 3'd1;
  localparam logic [2:0] BR_JN   = 3'd2;
  localparam logic [2:0] BR_JC   = 3'd3;
  localparam logic [2:0] BR_JMP  = 3'd4;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_NOT = 4'd1;
  localparam logic [3:0] ALU_LDD = 4'd2;
  localparam logic [3:0] ALU_STD = 4'd3;

  localparam int FLG_Z = 2;
  localparam int FLG_N = 1;
  localparam int FLG_C = 0;

endpackage

// File: rtl/flag_save_stack.sv
// LIFO of flag snapshots used across interrupt entry / return.
// Push and pop take effect on the clock edge; top is combinational from storage.
// Push when full and pop when empty are silently dropped; stall is applied by the caller.
module flag_save_stack #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             full,
  output logic             empty
);

  // Pointer carries one extra bit so full and empty are distinct without wrapping.
  localparam int PW = $clog2(DEPTH) + 1;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0]    ptr;
  logic [PW-1:0]    ptr_m1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full    = (ptr == PW'(DEPTH));
  assign empty   = (ptr == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty & ~do_push;
  assign ptr_m1  = ptr - PW'(1);
  assign top     = mem[ptr_m1[IW-1:0]];

  // Pointer moves up on push, down on pop; reset empties the stack.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (do_push) begin
      ptr <= ptr + PW'(1);
    end else if (do_pop) begin
      ptr <= ptr_m1;
    end
  end

  // Storage needs no reset: entries above the pointer are never read.
  always_ff @(posedge clk) begin
    if (!rst && do_push) begin
      mem[ptr[IW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/ccr_branch_unit.sv
// Condition-code register {Z,N,C} plus branch resolution and flag save stack.
// Flags update on the edge; branch taken/flush/pc appear one cycle after br_valid.
// stall freezes all state and forces the taken/flush pulse low so it never repeats.
module ccr_branch_unit
  import cpu_pkg::*;
#(
  parameter int N          = 16,
  parameter int SAVE_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         alu_carry,
  input  logic         alu_zero,
  input  logic         alu_neg,
  input  logic [3:0]   alu_op,
  input  logic         flag_wr_en,
  input  logic         setc,
  input  logic         clrc,
  input  logic         br_valid,
  input  logic [2:0]   br_type,
  input  logic [N-1:0] br_target,
  input  logic         stall,
  input  logic         int_save,
  input  logic         rti_restore,
  output logic [2:0]   flags_out,
  output logic         br_taken,
  output logic [N-1:0] br_pc,
  output logic         flush,
  output logic         save_full,
  output logic         save_empty
);

  logic [2:0] flags_q;
  logic [2:0] flags_nxt;
  logic [2:0] stack_top;
  logic       cond;
  logic       br_hit;
  logic       push;
  logic       pop;
  logic       restore_ok;

  assign flags_out = flags_q;
  assign flush     = br_taken;

  // Save wins over restore when both arrive together.
  assign push       = int_save & ~stall;
  assign pop        = rti_restore & ~int_save & ~stall;
  assign restore_ok = pop & ~save_empty;

  flag_save_stack #(
    .DEPTH (SAVE_DEPTH),
    .WIDTH (3)
  ) u_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_data (flags_q),
    .top       (stack_top),
    .full      (save_full),
    .empty     (save_empty)
  );

  // Branch condition from the registered flags only; reserved types never take.
  always_comb begin
    cond = 1'b0;
    case (br_type)
      BR_JZ:   cond = flags_q[FLG_Z];
      BR_JN:   cond = flags_q[FLG_N];
      BR_JC:   cond = flags_q[FLG_C];
      BR_JMP:  cond = 1'b1;
      default: cond = 1'b0;
    endcase
  end

  assign br_hit = br_valid & cond;

  // Next flags: sources applied lowest priority first so later ones override.
  always_comb begin
    flags_nxt = flags_q;
    if (flag_wr_en) begin
      case (alu_op)
        ALU_ADD: begin
          flags_nxt[FLG_Z] = alu_zero;
          flags_nxt[FLG_N] = alu_neg;
          flags_nxt[FLG_C] = alu_carry;
        end
        ALU_NOT, ALU_LDD: begin
          flags_nxt[FLG_Z] = alu_zero;
          flags_nxt[FLG_N] = alu_neg;
        end
        default: ;
      endcase
    end
    if (setc) begin
      flags_nxt[FLG_C] = 1'b1;
    end else if (clrc) begin
      flags_nxt[FLG_C] = 1'b0;
    end
    if (br_hit) begin
      case (br_type)
        BR_JZ:   flags_nxt[FLG_Z] = 1'b0;
        BR_JN:   flags_nxt[FLG_N] = 1'b0;
        BR_JC:   flags_nxt[FLG_C] = 1'b0;
        default: ;
      endcase
    end
    if (restore_ok) begin
      flags_nxt = stack_top;
    end
  end

  // Flag register and branch pulse; br_pc keeps its last redirect target.
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q  <= 3'b000;
      br_taken <= 1'b0;
      br_pc    <= '0;
    end else if (stall) begin
      br_taken <= 1'b0;
    end else begin
      flags_q  <= flags_nxt;
      br_taken <= br_hit;
      if (br_hit) begin
        br_pc <= br_target;
      end
    end
  end

endmodule
